// File: rtl/pipelined_addsub_pkg.sv
// Shared definitions for the pipelined add/subtract unit: operation mode
// encoding and the pipeline depth derivation.
package addsub_pkg;

  typedef enum logic {
    MODE_ADD = 1'b0,
    MODE_SUB = 1'b1
  } mode_e;

  // Number of SEG-bit stages needed to cover a WIDTH-bit operand.
  function automatic int unsigned calc_stages(int unsigned width, int unsigned seg);
    return (seg == 0) ? 0 : width / seg;
  endfunction

  // WIDTH must split evenly into at least one SEG-bit segment.
  function automatic bit cfg_ok(int unsigned width, int unsigned seg);
    return (seg >= 1) && (width >= seg) && ((width % seg) == 0);
  endfunction

endpackage

// File: rtl/pipelined_addsub_if.sv
// Operand/result handshake bundle for pipelined_addsub.
interface pipelined_addsub_if #(
  parameter int unsigned WIDTH = 16
) ();

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             ci;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] r;
  logic             co;
  logic             ovf;
  logic             zero;

  modport master (
    output in_valid, a, b, ci, sub, out_ready,
    input  in_ready, out_valid, r, co, ovf, zero
  );

  modport slave (
    input  in_valid, a, b, ci, sub, out_ready,
    output in_ready, out_valid, r, co, ovf, zero
  );

endinterface

// File: rtl/pipelined_addsub_seg.sv
// Combinational SEG-bit ripple adder slice; one instance per pipeline stage.
module addsub_seg #(
  parameter int unsigned SEG = 4
) (
  input  logic [SEG-1:0] a,
  input  logic [SEG-1:0] b,
  input  logic           cin,
  output logic [SEG-1:0] s,
  output logic           cout,
  output logic           ctop
);

  // Ripple the carry through the slice; ctop is the carry into the top bit.
  always_comb begin : ripple
    logic [SEG:0] c;
    c    = '0;
    s    = '0;
    c[0] = cin;
    for (int unsigned i = 0; i < SEG; i++) begin
      s[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    cout = c[SEG];
    ctop = c[SEG-1];
  end

endmodule

// File: rtl/pipelined_addsub.sv
// Pipelined WIDTH-bit add/subtract: an input register captures the operands,
// then one SEG-bit segment is resolved per stage with the carry registered
// between stages. The whole pipe advances or stalls as a single unit.
module pipelined_addsub
  import addsub_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned SEG   = 4
) (
  input logic              clk,
  input logic              rst,
  pipelined_addsub_if.slave bus
);

  localparam int unsigned STAGES = calc_stages(WIDTH, SEG);

  if (!cfg_ok(WIDTH, SEG)) begin : g_cfg_err
    $error("pipelined_addsub: WIDTH must be a non-zero multiple of SEG");
  end

  logic advance;
  logic take;

  // Register slot k feeds segment k: valid bit, raw operands (skew), carry
  // into segment k and the low result bits resolved so far.
  logic             v_q [STAGES];
  logic [WIDTH-1:0] a_q [STAGES];
  logic [WIDTH-1:0] b_q [STAGES];
  logic             c_q [STAGES];
  logic [WIDTH-1:0] r_q [STAGES];

  // Per-segment combinational results.
  logic [SEG-1:0]   ss   [STAGES];
  logic             sco  [STAGES];
  logic             sct  [STAGES];
  logic [WIDTH-1:0] part [STAGES];

  // Output stage.
  logic             out_v;
  logic [WIDTH-1:0] r_o;
  logic             co_o;
  logic             ovf_o;
  logic             zero_o;

  assign advance      = bus.out_ready | ~out_v;
  assign take         = bus.in_valid & advance;
  assign bus.in_ready = advance;

  assign bus.out_valid = out_v;
  assign bus.r         = r_o;
  assign bus.co        = co_o;
  assign bus.ovf       = ovf_o;
  assign bus.zero      = zero_o;

  for (genvar k = 0; k < STAGES; k++) begin : g_seg
    addsub_seg #(.SEG(SEG)) u_seg (
      .a    (a_q[k][k*SEG +: SEG]),
      .b    (b_q[k][k*SEG +: SEG]),
      .cin  (c_q[k]),
      .s    (ss[k]),
      .cout (sco[k]),
      .ctop (sct[k])
    );

    // Merge this segment's sum into the partial result carried so far.
    always_comb begin
      part[k]                = r_q[k];
      part[k][k*SEG +: SEG]  = ss[k];
    end
  end

  // Advance the valid chain, skew data and carries; the output registers only
  // take a new value when a valid op arrives, so bubbles leave them untouched.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned k = 0; k < STAGES; k++) begin
        v_q[k] <= 1'b0;
      end
      out_v  <= 1'b0;
      r_o    <= '0;
      co_o   <= 1'b0;
      ovf_o  <= 1'b0;
      zero_o <= 1'b0;
    end else if (advance) begin
      v_q[0] <= take;
      if (take) begin
        a_q[0] <= bus.a;
        b_q[0] <= (mode_e'(bus.sub) == MODE_SUB) ? ~bus.b : bus.b;
        c_q[0] <= (mode_e'(bus.sub) == MODE_SUB) ? 1'b1 : bus.ci;
        r_q[0] <= '0;
      end
      for (int unsigned k = 1; k < STAGES; k++) begin
        v_q[k] <= v_q[k-1];
        a_q[k] <= a_q[k-1];
        b_q[k] <= b_q[k-1];
        c_q[k] <= sco[k-1];
        r_q[k] <= part[k-1];
      end
      out_v <= v_q[STAGES-1];
      if (v_q[STAGES-1]) begin
        r_o    <= part[STAGES-1];
        co_o   <= sco[STAGES-1];
        ovf_o  <= sco[STAGES-1] ^ sct[STAGES-1];
        zero_o <= (part[STAGES-1] == '0);
      end
    end
  end

endmodule

// File: tb/tb_pipelined_addsub.sv
// Self-checking bench for pipelined_addsub (WIDTH=16, SEG=4).
module tb_pipelined_addsub;

  localparam int unsigned W = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pipelined_addsub_if #(.WIDTH(W)) bus ();

  pipelined_addsub #(.WIDTH(W), .SEG(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int unsigned n_chk = 0;
  int unsigned n_bad = 0;

  task automatic check_val(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Reference: plain integer arithmetic; packed as {zero, ovf, co, r}.
  function automatic logic [18:0] ref_op(logic [15:0] a, logic [15:0] b, logic ci, logic sub);
    longint    ua = a;
    longint    ub = b;
    longint    sa = $signed(a);
    longint    sb = $signed(b);
    longint    u;
    longint    s;
    logic      co;
    logic      ovf;
    logic [15:0] r;
    if (sub) begin
      u  = ua - ub;
      s  = sa - sb;
      co = (ua >= ub);
    end else begin
      u  = ua + ub + ci;
      s  = sa + sb + ci;
      co = (u > 65535);
    end
    r   = u[15:0];
    ovf = (s > 32767) || (s < -32768);
    return {(r == 16'h0000), ovf, co, r};
  endfunction

  // Monitor state
  logic [18:0] exp_q [$];
  logic [18:0] e_mon;
  logic [18:0] held;
  logic        stalled = 1'b0;
  int unsigned n_out = 0;
  longint      cyc = 0;
  longint      t_prev = 0;
  longint      t_last = 0;

  // Sample at the falling edge: handshakes seen here complete at the next rise.
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      exp_q.delete();
      stalled = 1'b0;
    end else begin
      check_val("in_ready", {31'b0, bus.in_ready}, {31'b0, bus.out_ready | ~bus.out_valid});
      if (stalled) begin
        check_val("stall_valid", {31'b0, bus.out_valid}, 32'd1);
        check_val("stall_hold", {13'b0, bus.zero, bus.ovf, bus.co, bus.r}, {13'b0, held});
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          check_val("unexpected_out", exp_q.size(), 32'd1);
        end else begin
          e_mon = exp_q.pop_front();
          check_val("result", {13'b0, bus.zero, bus.ovf, bus.co, bus.r}, {13'b0, e_mon});
        end
        n_out++;
        t_prev = t_last;
        t_last = cyc;
      end
      if (bus.in_valid && bus.in_ready)
        exp_q.push_back(ref_op(bus.a, bus.b, bus.ci, bus.sub));
      stalled = bus.out_valid && !bus.out_ready;
      held    = {bus.zero, bus.ovf, bus.co, bus.r};
    end
  end

  task automatic issue(logic [15:0] a, logic [15:0] b, logic ci, logic sub);
    int n = 0;
    bus.in_valid = 1'b1;
    bus.a        = a;
    bus.b        = b;
    bus.ci       = ci;
    bus.sub      = sub;
    @(negedge clk);
    while (!bus.in_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!bus.in_ready) check_val("issue_timeout", {31'b0, bus.in_ready}, 32'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic drain(string tag);
    int n = 0;
    while ((exp_q.size() != 0 || bus.out_valid) && n < 60) begin
      @(posedge clk);
      #1;
      n++;
    end
    check_val(tag, exp_q.size(), 32'd0);
  endtask

  // Called right after issue(): out_valid must rise exactly 4 edges later.
  task automatic check_latency(string tag);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_val(tag, {31'b0, bus.out_valid}, (i == 4) ? 32'd1 : 32'd0);
    end
    @(negedge clk);
    check_val({tag, "_once"}, {31'b0, bus.out_valid}, 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_out(string tag);
    int n = 0;
    @(negedge clk);
    while (!bus.out_valid && n < 20) begin
      n++;
      @(negedge clk);
    end
    if (!bus.out_valid) check_val({tag, "_timeout"}, {31'b0, bus.out_valid}, 32'd1);
  endtask

  function automatic logic [15:0] pick_operand();
    logic [15:0] v;
    case ($urandom_range(0, 5))
      0:       v = 16'h0000;
      1:       v = 16'hFFFF;
      2:       v = 16'h7FFF;
      3:       v = 16'h8000;
      default: v = 16'($urandom);
    endcase
    return v;
  endfunction

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        ci;
    logic        sub;
    logic [18:0] exp;   // {zero, ovf, co, r}
  } vec_t;

  vec_t vecs [7];

  int unsigned n0;

  initial begin
    vecs[0] = '{16'h1234, 16'h1111, 1'b0, 1'b0, {1'b0, 1'b0, 1'b0, 16'h2345}};
    vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, {1'b1, 1'b0, 1'b1, 16'h0000}};
    vecs[2] = '{16'hFFFF, 16'h0001, 1'b1, 1'b0, {1'b0, 1'b0, 1'b1, 16'h0001}};
    vecs[3] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, {1'b0, 1'b1, 1'b0, 16'h8000}};
    vecs[4] = '{16'h0005, 16'h0007, 1'b0, 1'b1, {1'b0, 1'b0, 1'b0, 16'hFFFE}};
    vecs[5] = '{16'h8000, 16'h0001, 1'b0, 1'b1, {1'b0, 1'b1, 1'b1, 16'h7FFF}};
    vecs[6] = '{16'h1234, 16'h1234, 1'b1, 1'b1, {1'b1, 1'b0, 1'b1, 16'h0000}};

    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.ci        = 1'b0;
    bus.sub       = 1'b0;
    bus.out_ready = 1'b1;
    rst           = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    @(negedge clk);
    check_val("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
    check_val("rst_r", {16'b0, bus.r}, 32'd0);
    check_val("rst_co", {31'b0, bus.co}, 32'd0);
    check_val("rst_ovf", {31'b0, bus.ovf}, 32'd0);
    check_val("rst_zero", {31'b0, bus.zero}, 32'd0);
    check_val("rst_in_ready", {31'b0, bus.in_ready}, 32'd1);
    @(posedge clk);
    #1;

    issue(16'h1234, 16'h1111, 1'b0, 1'b0);
    check_latency("latency");
    drain("latency_drain");

    // Directed vectors against hand-derived constants.
    foreach (vecs[i]) begin
      issue(vecs[i].a, vecs[i].b, vecs[i].ci, vecs[i].sub);
      wait_out("vec");
      check_val($sformatf("vec%0d", i), {13'b0, bus.zero, bus.ovf, bus.co, bus.r}, {13'b0, vecs[i].exp});
      @(posedge clk);
      #1;
      drain("vec_drain");
    end

    // Six back-to-back ops with a 3-cycle stall once results start.
    n0 = n_out;
    fork
      begin
        for (int i = 0; i < 6; i++)
          issue(pick_operand(), pick_operand(), 1'($urandom), 1'($urandom));
      end
      begin
        int n = 0;
        do begin
          @(posedge clk);
          #1;
          n++;
        end while (!bus.out_valid && n < 20);
        bus.out_ready = 1'b0;
        repeat (3) begin
          @(posedge clk);
          #1;
        end
        bus.out_ready = 1'b1;
      end
    join
    drain("stall_drain");
    check_val("stall_count", n_out - n0, 32'd6);

    // Bubble between two ops.
    n0 = n_out;
    issue(16'hABCD, 16'h1357, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    issue(16'h0100, 16'h0200, 1'b0, 1'b1);
    drain("bubble_drain");
    check_val("bubble_count", n_out - n0, 32'd2);
    check_val("bubble_spacing", 32'(t_last - t_prev), 32'd2);

    // Reset while three ops are in flight.
    n0 = n_out;
    issue(16'h1111, 16'h2222, 1'b0, 1'b0);
    issue(16'h3333, 16'h4444, 1'b0, 1'b1);
    issue(16'h5555, 16'h6666, 1'b1, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check_val("flush_valid", {31'b0, bus.out_valid}, 32'd0);
      check_val("flush_r", {16'b0, bus.r}, 32'd0);
    end
    check_val("flush_count", n_out - n0, 32'd0);
    @(posedge clk);
    #1;
    issue(16'hC000, 16'h4000, 1'b0, 1'b0);
    check_latency("post_rst_latency");
    drain("post_rst_drain");
    check_val("post_rst_count", n_out - n0, 32'd1);

    // Random traffic with random backpressure.
    for (int i = 0; i < 400; i++) begin
      bus.in_valid  = 1'($urandom);
      bus.a         = pick_operand();
      bus.b         = pick_operand();
      bus.ci        = 1'($urandom);
      bus.sub       = 1'($urandom);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk);
      #1;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    drain("rand_drain");

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
